// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer sharing one memory_interface_v3 between the fetch and load/store ports.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin on contention; default is data-over-fetch priority.
module mem_port_arbiter #(
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [1:0]        d_word_type,
    input  logic              d_is_signed,
    output logic              d_gnt,
    output logic              d_done,
    output logic [31:0]       d_rdata,
    output logic              mi_load,
    output logic              mi_store,
    output logic [ADDR_W-1:0] mi_address,
    output logic [31:0]       mi_data_in,
    output logic [1:0]        mi_word_type,
    output logic              mi_is_signed,
    input  logic [31:0]       mi_data_out,
    input  logic              mi_output_valid,
    input  logic              mi_write_ready,
    input  logic              mi_busy,
    output logic              arb_busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic              start_s;
    logic              pick_d_s;
    logic              resp_load_s;
    logic              owner_d_r;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wdata_r;
    logic [1:0]        word_type_r;
    logic              is_signed_r;
    logic [31:0]       if_rdata_r;
    logic [31:0]       d_rdata_r;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic prefer_if_r;

    // On contention the port that lost the last completed transaction wins.
    always_comb begin
        if (d_req && if_req) begin
            pick_d_s = ~prefer_if_r;
        end else begin
            pick_d_s = d_req;
        end
    end

    // Pointer records the owner of each completed transaction.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prefer_if_r <= 1'b0;
        end else if (state_r == ST_DONE) begin
            prefer_if_r <= owner_d_r;
        end
    end
`else
    // Fixed priority: the data port beats fetch.
    always_comb begin
        pick_d_s = d_req;
    end
`endif

    assign start_s     = (state_r == ST_IDLE) && !mi_busy && (if_req || d_req);
    assign resp_load_s = (state_r == ST_WAIT) && !we_r && mi_output_valid;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; only the strobe matching the owner's direction ends WAIT.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_next_s = ST_WAIT;
            ST_WAIT: begin
                if (we_r ? mi_write_ready : mi_output_valid) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Owner registers capture the winning request at the arbitration edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            owner_d_r   <= 1'b0;
            we_r        <= 1'b0;
            addr_r      <= {ADDR_W{1'b0}};
            wdata_r     <= 32'h0000_0000;
            word_type_r <= 2'b00;
            is_signed_r <= 1'b0;
        end else if (start_s) begin
            owner_d_r <= pick_d_s;
            if (pick_d_s) begin
                we_r        <= d_we;
                addr_r      <= d_addr;
                wdata_r     <= d_wdata;
                word_type_r <= d_word_type;
                is_signed_r <= d_is_signed;
            end else begin
                we_r        <= 1'b0;
                addr_r      <= if_addr;
                wdata_r     <= 32'h0000_0000;
                word_type_r <= 2'b10;
                is_signed_r <= 1'b0;
            end
        end
    end

    // Read data is steered to the owning port and held until its next load.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if_rdata_r <= 32'h0000_0000;
            d_rdata_r  <= 32'h0000_0000;
        end else if (resp_load_s) begin
            if (owner_d_r) begin
                d_rdata_r <= mi_data_out;
            end else begin
                if_rdata_r <= mi_data_out;
            end
        end
    end

    assign if_rdata = if_rdata_r;
    assign d_rdata  = d_rdata_r;

    // Output decode from the registered state and owner registers only.
    always_comb begin
        if_gnt   = 1'b0;
        d_gnt    = 1'b0;
        if_valid = 1'b0;
        d_done   = 1'b0;
        mi_load  = 1'b0;
        mi_store = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if_gnt = 1'b0;
            end
            ST_ISSUE: begin
                if_gnt   = ~owner_d_r;
                d_gnt    = owner_d_r;
                mi_load  = ~we_r;
                mi_store = we_r;
            end
            ST_WAIT: begin
                mi_load = 1'b0;
            end
            ST_DONE: begin
                if_valid = ~owner_d_r;
                d_done   = owner_d_r;
            end
            default: begin
                if_gnt = 1'b0;
            end
        endcase
        if (state_r != ST_IDLE) begin
            arb_busy     = 1'b1;
            mi_address   = addr_r;
            mi_data_in   = wdata_r;
            mi_word_type = word_type_r;
            mi_is_signed = is_signed_r;
        end else begin
            arb_busy     = 1'b0;
            mi_address   = {ADDR_W{1'b0}};
            mi_data_in   = 32'h0000_0000;
            mi_word_type = 2'b00;
            mi_is_signed = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, corner sequences and random traffic
// against a byte-level reference memory; a small interface model answers the commands.
module tb_mem_port_arbiter;
    localparam int AW = 13;
    localparam int MEM_BYTES = 8192;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt, if_valid;
    logic [31:0]   if_rdata;
    logic          d_req, d_we;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic [1:0]    d_word_type;
    logic          d_is_signed;
    logic          d_gnt, d_done;
    logic [31:0]   d_rdata;
    logic          mi_load, mi_store;
    logic [AW-1:0] mi_address;
    logic [31:0]   mi_data_in;
    logic [1:0]    mi_word_type;
    logic          mi_is_signed;
    logic [31:0]   mi_data_out;
    logic          mi_output_valid, mi_write_ready;
    logic          mi_busy;
    logic          arb_busy;
    logic          any_out;

    mem_port_arbiter #(.ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_word_type(d_word_type),
        .d_is_signed(d_is_signed), .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
        .mi_load(mi_load), .mi_store(mi_store), .mi_address(mi_address), .mi_data_in(mi_data_in),
        .mi_word_type(mi_word_type), .mi_is_signed(mi_is_signed), .mi_data_out(mi_data_out),
        .mi_output_valid(mi_output_valid), .mi_write_ready(mi_write_ready), .mi_busy(mi_busy),
        .arb_busy(arb_busy)
    );

    always #5 clk = ~clk;

    assign any_out = |{if_gnt, if_valid, if_rdata, d_gnt, d_done, d_rdata, mi_load, mi_store,
                       mi_address, mi_data_in, mi_word_type, mi_is_signed, arb_busy};

    int n_vec = 0;
    int n_err = 0;
    logic [7:0]  ref_mem [MEM_BYTES];
    logic [7:0]  dev_mem [MEM_BYTES];
    logic [31:0] cur_if_rdata = 32'h0;
    logic [31:0] cur_d_rdata  = 32'h0;
    int          resp_lat = 1;
    bit          stray_en = 1'b0;

    typedef struct {
        logic          is_d;
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [1:0]    wt;
        logic          sgn;
        int            lat;
        logic [31:0]   exp;
    } vec_t;
    vec_t vt [13];

    function automatic int nbytes(input logic [1:0] wt);
        return (wt == 2'b00) ? 1 : ((wt == 2'b01) ? 2 : 4);
    endfunction

    function automatic logic [31:0] ext(input logic [31:0] raw, input logic [1:0] wt, input logic sgn);
        logic [31:0] r;
        case (wt)
            2'b00:   r = sgn ? {{24{raw[7]}}, raw[7:0]} : {24'h0, raw[7:0]};
            2'b01:   r = sgn ? {{16{raw[15]}}, raw[15:0]} : {16'h0, raw[15:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

    // Reference memory: little-endian bytes; returns the load result (0 for stores).
    function automatic logic [31:0] ref_access(input logic we, input logic [AW-1:0] addr,
                                               input logic [31:0] wdata, input logic [1:0] wt,
                                               input logic sgn);
        logic [31:0] raw;
        raw = 32'h0;
        for (int i = 0; i < nbytes(wt); i++) begin
            if (we) ref_mem[(int'(addr) + i) % MEM_BYTES] = wdata[8*i +: 8];
            raw[8*i +: 8] = ref_mem[(int'(addr) + i) % MEM_BYTES];
        end
        return we ? 32'h0 : ext(raw, wt, sgn);
    endfunction

    // Interface model: executes each command pulse, answers after resp_lat cycles.
    bit          pend, pend_we, pend_stray;
    int          lat_cnt;
    logic [31:0] pend_data, dev_raw;
    initial begin
        mi_output_valid = 1'b0;
        mi_write_ready  = 1'b0;
        mi_data_out     = 32'hCCCC_CCCC;
        pend = 1'b0;
        for (int i = 0; i < MEM_BYTES; i++) dev_mem[i] = 8'h00;
        forever begin
            @(negedge clk);
            mi_output_valid = 1'b0;
            mi_write_ready  = 1'b0;
            mi_data_out     = 32'hCCCC_CCCC;
            if (pend) begin
                if (lat_cnt <= 1) begin
                    if (pend_we) mi_write_ready = 1'b1;
                    else begin
                        mi_output_valid = 1'b1;
                        mi_data_out     = pend_data;
                    end
                    pend = 1'b0;
                end else begin
                    if (pend_stray) begin
                        if (pend_we) begin
                            mi_output_valid = 1'b1;
                            mi_data_out     = 32'h5A5A_A5A5;
                        end else mi_write_ready = 1'b1;
                        pend_stray = 1'b0;
                    end
                    lat_cnt--;
                end
            end
            if (mi_load || mi_store) begin
                dev_raw = 32'h0;
                for (int i = 0; i < nbytes(mi_word_type); i++) begin
                    if (mi_store) dev_mem[(int'(mi_address) + i) % MEM_BYTES] = mi_data_in[8*i +: 8];
                    dev_raw[8*i +: 8] = dev_mem[(int'(mi_address) + i) % MEM_BYTES];
                end
                pend_data  = ext(dev_raw, mi_word_type, mi_is_signed);
                pend       = 1'b1;
                pend_we    = mi_store;
                pend_stray = stray_en;
                lat_cnt    = resp_lat;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at the IDLE negedge where the request was raised; returns at the following IDLE negedge.
    task automatic finish_txn(input logic is_d, input logic we, input logic [AW-1:0] addr,
                              input logic [31:0] wdata, input logic [1:0] wt, input logic sgn,
                              input int lat, input logic [31:0] exp);
        logic bad;
        @(negedge clk);
        chk("gnt", 32'(is_d ? d_gnt : if_gnt), 32'd1);
        chk("other_gnt", 32'(is_d ? if_gnt : d_gnt), 32'd0);
        chk("cmd", 32'({mi_load, mi_store}), 32'({~we, we}));
        chk("mi_address", 32'(mi_address), 32'(addr));
        chk("mi_attr", 32'({mi_word_type, mi_is_signed}), 32'({wt, sgn}));
        if (we) chk("mi_data_in", mi_data_in, wdata);
        d_req  = 1'b0;
        if_req = 1'b0;
        bad = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (d_done || if_valid || d_gnt || if_gnt || mi_load || mi_store || !arb_busy ||
                mi_address !== addr) bad = 1'b1;
        end
        chk("wait_quiet", 32'(bad), 32'd0);
        @(negedge clk);
        chk("done", 32'(is_d ? d_done : if_valid), 32'd1);
        chk("other_done", 32'(is_d ? if_valid : d_done), 32'd0);
        if (!we) begin
            if (is_d) cur_d_rdata = exp;
            else      cur_if_rdata = exp;
        end
        chk("d_rdata", d_rdata, cur_d_rdata);
        chk("if_rdata", if_rdata, cur_if_rdata);
        @(negedge clk);
        chk("back_idle", 32'({d_done, if_valid, arb_busy}), 32'd0);
    endtask

    task automatic do_txn(input logic is_d, input logic we, input logic [AW-1:0] addr,
                          input logic [31:0] wdata, input logic [1:0] wt, input logic sgn,
                          input int lat, input logic [31:0] exp);
        resp_lat = lat;
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
            d_word_type = wt; d_is_signed = sgn;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        finish_txn(is_d, we, addr, wdata, wt, sgn, lat, exp);
    endtask

    logic          r_is_d, r_we, r_sgn, seen, who;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_wdata, r_exp;
    logic [1:0]    r_wt;
    int            r_lat, waited;
    logic          exp_seq [4];

    initial begin
        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h00;
        reset = 1'b0; mi_busy = 1'b0;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = 32'h0; d_word_type = 2'b00; d_is_signed = 1'b0;

        vt[0]  = '{1'b1, 1'b1, 13'h0040, 32'hDEAD_BEEF, 2'b10, 1'b0, 1, 32'h0};
        vt[1]  = '{1'b0, 1'b0, 13'h0040, 32'h0,         2'b10, 1'b0, 3, 32'hDEAD_BEEF};
        vt[2]  = '{1'b1, 1'b1, 13'h0013, 32'h0000_00F0, 2'b00, 1'b0, 2, 32'h0};
        vt[3]  = '{1'b1, 1'b0, 13'h0013, 32'h0,         2'b00, 1'b1, 1, 32'hFFFF_FFF0};
        vt[4]  = '{1'b1, 1'b0, 13'h0013, 32'h0,         2'b00, 1'b0, 2, 32'h0000_00F0};
        vt[5]  = '{1'b1, 1'b0, 13'h0042, 32'h0,         2'b01, 1'b1, 1, 32'hFFFF_DEAD};
        vt[6]  = '{1'b1, 1'b0, 13'h0040, 32'h0,         2'b01, 1'b0, 1, 32'h0000_BEEF};
        vt[7]  = '{1'b1, 1'b1, 13'h0012, 32'h1234_8001, 2'b01, 1'b0, 1, 32'h0};
        vt[8]  = '{1'b1, 1'b0, 13'h0010, 32'h0,         2'b10, 1'b0, 2, 32'h8001_0000};
        vt[9]  = '{1'b0, 1'b0, 13'h0010, 32'h0,         2'b10, 1'b0, 1, 32'h8001_0000};
        vt[10] = '{1'b1, 1'b0, 13'h0041, 32'h0,         2'b00, 1'b1, 1, 32'hFFFF_FFBE};
        vt[11] = '{1'b1, 1'b1, 13'h1FFC, 32'hA5A5_5A5A, 2'b10, 1'b0, 4, 32'h0};
        vt[12] = '{1'b0, 1'b0, 13'h1FFC, 32'h0,         2'b10, 1'b0, 2, 32'hA5A5_5A5A};

        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'(any_out), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", 32'(any_out), 32'd0);

        for (int i = 0; i < 13; i++) begin
            void'(ref_access(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].wt, vt[i].sgn));
            do_txn(vt[i].is_d, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].wt, vt[i].sgn, vt[i].lat, vt[i].exp);
        end

        // Reset while a load is waiting: everything clears and no completion ever appears.
        resp_lat = 20;
        d_req = 1'b1; d_we = 1'b0; d_addr = 13'h0040; d_word_type = 2'b10; d_is_signed = 1'b0;
        @(negedge clk);
        chk("abort_gnt", 32'(d_gnt), 32'd1);
        d_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_in_wait", 32'(arb_busy), 32'd1);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("reset_in_wait", 32'(any_out), 32'd0);
        end
        reset = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (d_done || if_valid || arb_busy) seen = 1'b1;
        end
        chk("abort_no_done", 32'(seen), 32'd0);
        cur_d_rdata = 32'h0;
        cur_if_rdata = 32'h0;

        // Contention with both requests held.
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_seq = '{1'b1, 1'b1, 1'b1, 1'b0};
`endif
        resp_lat = 1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 13'h0040; d_word_type = 2'b10; d_is_signed = 1'b0;
        if_req = 1'b1; if_addr = 13'h1FFC;
        for (int g = 0; g < 4; g++) begin
            waited = 0; seen = 1'b0; who = 1'b0;
            while (!seen && waited < 20) begin
                @(negedge clk);
                waited++;
                if (d_gnt || if_gnt) begin
                    seen = 1'b1;
                    who = d_gnt;
                    chk("cont_exclusive", 32'(d_gnt && if_gnt), 32'd0);
                end
            end
            chk("cont_gnt_seen", 32'(seen), 32'd1);
            chk("cont_owner", 32'(who), 32'(exp_seq[g]));
            chk("cont_spacing", 32'(waited), (g == 0) ? 32'd1 : 32'd4);
            if (g == 2) d_req = 1'b0;
            if (g == 3) if_req = 1'b0;
        end
        repeat (3) @(negedge clk);
        cur_d_rdata  = ref_access(1'b0, 13'h0040, 32'h0, 2'b10, 1'b0);
        cur_if_rdata = ref_access(1'b0, 13'h1FFC, 32'h0, 2'b10, 1'b0);
        chk("cont_d_rdata", d_rdata, cur_d_rdata);
        chk("cont_if_rdata", if_rdata, cur_if_rdata);
        chk("cont_idle", 32'(arb_busy), 32'd0);

        // Busy hold-off: grant comes one cycle after mi_busy falls.
        mi_busy = 1'b1;
        resp_lat = 1;
        void'(ref_access(1'b1, 13'h0100, 32'h0BAD_F00D, 2'b10, 1'b0));
        d_req = 1'b1; d_we = 1'b1; d_addr = 13'h0100; d_wdata = 32'h0BAD_F00D;
        d_word_type = 2'b10; d_is_signed = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (d_gnt || if_gnt || arb_busy || mi_store) seen = 1'b1;
        end
        chk("busy_holdoff", 32'(seen), 32'd0);
        mi_busy = 1'b0;
        finish_txn(1'b1, 1'b1, 13'h0100, 32'h0BAD_F00D, 2'b10, 1'b0, 1, 32'h0);
        r_exp = ref_access(1'b0, 13'h0100, 32'h0, 2'b10, 1'b0);
        do_txn(1'b0, 1'b0, 13'h0100, 32'h0, 2'b10, 1'b0, 2, r_exp);

        // Stray strobe of the wrong direction during WAIT is ignored.
        stray_en = 1'b1;
        void'(ref_access(1'b1, 13'h0200, 32'h1122_3344, 2'b00, 1'b0));
        do_txn(1'b1, 1'b1, 13'h0200, 32'h1122_3344, 2'b00, 1'b0, 4, 32'h0);
        r_exp = ref_access(1'b0, 13'h0200, 32'h0, 2'b01, 1'b1);
        do_txn(1'b1, 1'b0, 13'h0200, 32'h0, 2'b01, 1'b1, 4, r_exp);
        stray_en = 1'b0;

        // Random single-requester traffic against the reference memory.
        for (int n = 0; n < 150; n++) begin
            r_is_d = 1'($urandom_range(0, 1));
            r_we   = r_is_d ? 1'($urandom_range(0, 1)) : 1'b0;
            r_wt   = r_is_d ? 2'($urandom_range(0, 2)) : 2'b10;
            r_sgn  = r_is_d ? 1'($urandom_range(0, 1)) : 1'b0;
            r_addr = AW'($urandom_range(0, MEM_BYTES - 1));
            if (r_wt == 2'b01) r_addr[0] = 1'b0;
            if (r_wt == 2'b10) r_addr[1:0] = 2'b00;
            r_wdata = $urandom;
            r_lat   = int'($urandom_range(1, 4));
            r_exp   = ref_access(r_we, r_addr, r_wdata, r_wt, r_sgn);
            do_txn(r_is_d, r_we, r_addr, r_wdata, r_wt, r_sgn, r_lat, r_exp);
            repeat (int'($urandom_range(0, 2))) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
